// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry PC/instruction queue in front of decode.
// One read in flight at a time; a redirect flushes the queue and any outstanding response.
module fetch_queue #(
  parameter int          INSTR_W  = 24,
  parameter int          PC_W     = 16,
  parameter int          DEPTH    = 4,
  parameter int          PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetchEn,
  input  logic                       pcWrEn,
  input  logic [PC_W-1:0]            newPc,
  output logic                       imemRdEn,
  output logic [PC_W-1:0]            imemAddr,
  input  logic [INSTR_W-1:0]         imemRdData,
  output logic                       instrValid,
  input  logic                       instrReady,
  output logic [INSTR_W-1:0]         instruction,
  output logic [PC_W-1:0]            instrPc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int              AW   = $clog2(DEPTH);
  localparam int              CW   = AW + 1;
  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] RPC  = PC_W'(RESET_PC);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic               req_valid_q, req_valid_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]    pc_q    [DEPTH];

  logic               head_valid, pop, push, credit_ok, issue;
  logic [CW:0]        occupancy;

  // Stage 0: issue decision against the current fetch PC
  always_comb begin
    head_valid = reset & (count_q != '0);
    pop        = head_valid & instrReady & ~pcWrEn;
    push       = req_valid_q & ~pcWrEn;
    // Count the outstanding read as already occupying a slot so a push can never overflow.
    occupancy  = {1'b0, count_q} + (CW+1)'(req_valid_q) - (CW+1)'(pop);
    credit_ok  = occupancy < (CW+1)'(DEPTH);
    issue      = reset & fetchEn & (pcWrEn | credit_ok);
  end

  assign imemRdEn    = issue;
  assign imemAddr    = pcWrEn ? newPc : fetch_pc_q;
  assign instrValid  = head_valid;
  assign instruction = head_valid ? instr_q[rd_ptr_q] : '0;
  assign instrPc     = head_valid ? pc_q[rd_ptr_q] : '0;
  assign count       = count_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = issue;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (pcWrEn) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      req_pc_d   = newPc;
      fetch_pc_d = issue ? newPc + STEP : newPc;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + STEP;
      end
    end
  end

  // Stage 1: control registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q  <= RPC;
      req_valid_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Stage 1: queue storage and in-flight PC
  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
    if (push) begin
      instr_q[wr_ptr_q] <= imemRdData;
      pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: table-driven startup, directed corner sequences, and a
// randomized run scored by an in-order PC-stream model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, fetchEn, pcWrEn, instrReady;
  logic [15:0] newPc;
  logic        imemRdEn;
  logic [15:0] imemAddr;
  logic [23:0] imemRdData;
  logic        instrValid;
  logic [23:0] instruction;
  logic [15:0] instrPc;
  logic [2:0]  count;

  logic        reset2, fetchEn2, pcWrEn2, instrReady2;
  logic [15:0] newPc2;
  logic        imemRdEn2;
  logic [15:0] imemAddr2;
  logic [23:0] imemRdData2;
  logic        instrValid2;
  logic [23:0] instruction2;
  logic [15:0] instrPc2;
  logic [2:0]  count2;

  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [23:0] memval(input logic [15:0] a);
    case (a)
      16'd0:   memval = 24'h123456;
      16'd1:   memval = 24'h789101;
      16'd2:   memval = 24'h112131;
      16'd3:   memval = 24'hABCDEF;
      16'd4:   memval = 24'h000004;
      default: memval = {8'h5A, a};
    endcase
  endfunction

  always @(posedge clk) if (imemRdEn)  imemRdData  <= memval(imemAddr);
  always @(posedge clk) if (imemRdEn2) imemRdData2 <= memval(imemAddr2);

  fetch_queue u_dut (
    .clk(clk), .reset(reset), .fetchEn(fetchEn), .pcWrEn(pcWrEn), .newPc(newPc),
    .imemRdEn(imemRdEn), .imemAddr(imemAddr), .imemRdData(imemRdData),
    .instrValid(instrValid), .instrReady(instrReady), .instruction(instruction),
    .instrPc(instrPc), .count(count)
  );

  fetch_queue #(.RESET_PC(32'hFFFE)) u_dut2 (
    .clk(clk), .reset(reset2), .fetchEn(fetchEn2), .pcWrEn(pcWrEn2), .newPc(newPc2),
    .imemRdEn(imemRdEn2), .imemAddr(imemAddr2), .imemRdData(imemRdData2),
    .instrValid(instrValid2), .instrReady(instrReady2), .instruction(instruction2),
    .instrPc(instrPc2), .count(count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after release (reset=1 just driven).
  task automatic do_reset(input logic fe, input logic rdy);
    reset = 1'b0; pcWrEn = 1'b0; newPc = '0; fetchEn = fe; instrReady = rdy;
    repeat (2) next_cycle();
    reset = 1'b1;
  endtask

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        v;
    logic [23:0] ins;
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        rd;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] seq_pc [5];
    logic        popped, got;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 24'h000000, 16'h0000, 3'd0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 24'h000000, 16'h0000, 3'd0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 24'h123456, 16'h0000, 3'd1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 24'h789101, 16'h0001, 3'd1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 24'h112131, 16'h0002, 3'd1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 24'hABCDEF, 16'h0003, 3'd1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 24'h000004, 16'h0004, 3'd1, 1'b1};

    reset2 = 1'b0; fetchEn2 = 1'b1; pcWrEn2 = 1'b0; newPc2 = '0; instrReady2 = 1'b1;
    reset = 1'b0; fetchEn = 1'b0; pcWrEn = 1'b0; newPc = '0; instrReady = 1'b0;
    repeat (2) next_cycle();
    chk("rst_valid", instrValid, 1'b0);
    chk("rst_rden", imemRdEn, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_instr", instruction, 24'h0);

    // Startup stream from the table
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      fetchEn = tbl[i].fe; instrReady = tbl[i].rdy;
      #1;
      chk($sformatf("t1_valid[%0d]", i), instrValid, tbl[i].v);
      chk($sformatf("t1_instr[%0d]", i), instruction, tbl[i].ins);
      chk($sformatf("t1_pc[%0d]", i), instrPc, tbl[i].pc);
      chk($sformatf("t1_count[%0d]", i), count, tbl[i].cnt);
      chk($sformatf("t1_rden[%0d]", i), imemRdEn, tbl[i].rd);
      next_cycle();
    end

    // Fill with decode stalled, then drain in order
    do_reset(1'b1, 1'b0);
    repeat (6) next_cycle();
    #1;
    chk("full_count", count, 3'd4);
    chk("full_rden", imemRdEn, 1'b0);
    chk("full_addr", imemAddr, 16'h0004);
    chk("full_head_instr", instruction, 24'h123456);
    chk("full_head_pc", instrPc, 16'h0000);
    instrReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("drain_valid[%0d]", i), instrValid, 1'b1);
      chk($sformatf("drain_pc[%0d]", i), instrPc, 16'(i));
      chk($sformatf("drain_instr[%0d]", i), instruction, memval(16'(i)));
      next_cycle();
    end

    // Redirect while full and stalled
    instrReady = 1'b0;
    repeat (8) next_cycle();
    #1;
    chk("refill_count", count, 3'd4);
    pcWrEn = 1'b1; newPc = 16'h0002;
    #1;
    chk("rdfull_rden", imemRdEn, 1'b1);
    chk("rdfull_addr", imemAddr, 16'h0002);
    next_cycle();
    pcWrEn = 1'b0;
    #1;
    chk("rdfull_valid_k1", instrValid, 1'b0);
    chk("rdfull_count_k1", count, 3'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk($sformatf("rdfull_hold_pc[%0d]", i), instrPc, 16'h0002);
      chk($sformatf("rdfull_hold_instr[%0d]", i), instruction, 24'h112131);
    end

    // Redirect with three queued and decode ready
    do_reset(1'b1, 1'b0);
    repeat (4) next_cycle();
    #1;
    chk("rd3_count", count, 3'd3);
    instrReady = 1'b1; pcWrEn = 1'b1; newPc = 16'h0001;
    #1;
    chk("rd3_rden", imemRdEn, 1'b1);
    chk("rd3_addr", imemAddr, 16'h0001);
    next_cycle();
    pcWrEn = 1'b0;
    #1;
    chk("rd3_valid_k1", instrValid, 1'b0);
    chk("rd3_count_k1", count, 3'd0);
    next_cycle();
    chk("rd3_valid_k2", instrValid, 1'b1);
    chk("rd3_pc_k2", instrPc, 16'h0001);
    chk("rd3_instr_k2", instruction, 24'h789101);
    next_cycle();
    chk("rd3_pc_k3", instrPc, 16'h0002);
    chk("rd3_instr_k3", instruction, 24'h112131);

    // Reset with entries queued and a read outstanding
    do_reset(1'b1, 1'b0);
    repeat (4) next_cycle();
    reset = 1'b0;
    #1;
    chk("mrst_valid_now", instrValid, 1'b0);
    chk("mrst_rden_now", imemRdEn, 1'b0);
    chk("mrst_instr_now", instruction, 24'h0);
    next_cycle();
    chk("mrst_count", count, 3'd0);
    chk("mrst_valid", instrValid, 1'b0);
    chk("mrst_rden", imemRdEn, 1'b0);
    chk("mrst_instr", instruction, 24'h0);
    chk("mrst_pc", instrPc, 16'h0);
    next_cycle();
    reset = 1'b1; instrReady = 1'b1;
    repeat (2) next_cycle();
    chk("mrst_restart_valid", instrValid, 1'b1);
    chk("mrst_restart_pc", instrPc, 16'h0000);
    chk("mrst_restart_instr", instruction, 24'h123456);

    // PC wrap on the second instance
    reset2 = 1'b1;
    repeat (2) next_cycle();
    seq_pc[0] = 16'hFFFE; seq_pc[1] = 16'hFFFF; seq_pc[2] = 16'h0000; seq_pc[3] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_valid[%0d]", i), instrValid2, 1'b1);
      chk($sformatf("wrap_pc[%0d]", i), instrPc2, seq_pc[i]);
      chk($sformatf("wrap_instr[%0d]", i), instruction2, memval(seq_pc[i]));
      next_cycle();
    end

    // Randomized run against the delivered-PC-stream model
    do_reset(1'b1, 1'b1);
    exp_pc = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      fetchEn    = ($urandom % 8) != 0;
      instrReady = ($urandom % 3) != 0;
      pcWrEn     = ($urandom % 16) == 0;
      newPc      = (($urandom % 4) == 0) ? 16'hFFFC + 16'($urandom % 4) : 16'($urandom % 64);
      reset      = ($urandom % 200) != 0;
      #1;
      popped = instrValid & instrReady & ~pcWrEn;
      if (!reset) begin
        chk("rnd_rst_valid", instrValid, 1'b0);
        chk("rnd_rst_rden", imemRdEn, 1'b0);
      end else if (instrValid) begin
        chk("rnd_instr_mem", instruction, memval(instrPc));
        if (popped) chk("rnd_pop_pc", instrPc, exp_pc);
      end else begin
        chk("rnd_empty_out", {instruction, instrPc}, 40'h0);
      end
      if (reset && pcWrEn && fetchEn) chk("rnd_redirect_addr", {imemRdEn, imemAddr}, {1'b1, newPc});
      if (reset && count == 3'd4 && !pcWrEn && !instrReady) chk("rnd_full_rden", imemRdEn, 1'b0);
      if (count > 3'd4) chk("rnd_count_bound", count, 3'd4);
      if (!reset)      exp_pc = 16'h0000;
      else if (pcWrEn) exp_pc = newPc;
      else if (popped) exp_pc = exp_pc + 16'd1;
      next_cycle();
    end

    reset = 1'b1; fetchEn = 1'b1; instrReady = 1'b1; pcWrEn = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (instrValid) got = 1'b1;
      else next_cycle();
    end
    chk("liveness_valid", got, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
